// File: rtl/game_control.sv
// game_control: top-level game sequencer. Runs the IDLE -> PLAY -> HIT -> OVER flow,
// tracks level, lives, active enemy squares and enemy speed, and emits a one-clk
// clear pulse whenever play (re)starts.
//   clk, reset (async active-low)
//   refresh_tick : one-clk pulse per video frame
//   start        : debounced start button (level), only 0->1 edges act
//   collision    : main square hit flag, sampled only on PLAY frame ticks
//   state        : 00 IDLE, 01 PLAY, 10 HIT, 11 OVER
//   game_en      : square-motion enable (high in PLAY)
//   clear        : one-clk pulse to re-initialise square positions
//   num_enabled  : active enemy squares, level/speed/lives : game status
module game_control #(
  parameter int unsigned FRAMES_PER_LEVEL = 600,
  parameter int unsigned HIT_FRAMES       = 60,
  parameter int unsigned START_SQUARES    = 4,
  parameter int unsigned LIVES            = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       start,
  input  logic       collision,
  output logic [1:0] state,
  output logic       game_en,
  output logic       clear,
  output logic [4:0] num_enabled,
  output logic [2:0] speed,
  output logic [3:0] level,
  output logic [1:0] lives
);

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned HIT_W   = 8;
  localparam logic [FRAME_W-1:0] FRAME_LAST  = FRAME_W'(FRAMES_PER_LEVEL - 1);
  localparam logic [HIT_W-1:0]   HIT_LAST    = HIT_W'(HIT_FRAMES - 1);
  localparam logic [4:0]         SQ_START    = 5'(START_SQUARES);
  localparam logic [1:0]         LIVES_START = 2'(LIVES);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_HIT  = 2'b10,
    S_OVER = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic               game_en_q, game_en_d;
  logic               clear_q, clear_d;
  logic [4:0]         num_q, num_d;
  logic [2:0]         speed_q, speed_d;
  logic [3:0]         level_q, level_d;
  logic [1:0]         lives_q, lives_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [HIT_W-1:0]   hit_q, hit_d;
  logic               start_q, start_d;
  logic               armed_q, armed_d;
  logic               start_evt_c;

  // armed_q only sets once start has been seen low, so a button held through
  // reset release never masquerades as a fresh press.
  assign start_evt_c = start & ~start_q & armed_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      game_en_q <= 1'b0;
      clear_q   <= 1'b0;
      num_q     <= SQ_START;
      speed_q   <= 3'd1;
      level_q   <= 4'd0;
      lives_q   <= 2'd0;
      frame_q   <= '0;
      hit_q     <= '0;
      start_q   <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      game_en_q <= game_en_d;
      clear_q   <= clear_d;
      num_q     <= num_d;
      speed_q   <= speed_d;
      level_q   <= level_d;
      lives_q   <= lives_d;
      frame_q   <= frame_d;
      hit_q     <= hit_d;
      start_q   <= start_d;
      armed_q   <= armed_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    num_d   = num_q;
    level_d = level_q;
    lives_d = lives_q;
    frame_d = frame_q;
    hit_d   = hit_q;
    start_d = start;
    armed_d = armed_q | ~start;

    case (state_q)
      S_IDLE: begin
        if (start_evt_c) begin
          state_d = S_PLAY;
          clear_d = 1'b1;
          lives_d = LIVES_START;
          level_d = 4'd0;
          num_d   = SQ_START;
          frame_d = '0;
        end
      end
      S_PLAY: begin
        if (refresh_tick) begin
          if (collision) begin
            // Collision wins over a level step landing on the same frame.
            state_d = S_HIT;
            hit_d   = '0;
            lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          end else if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            level_d = (level_q == 4'd15) ? level_q : level_q + 4'd1;
            num_d   = (num_q == 5'd16) ? num_q : num_q + 5'd1;
          end else begin
            frame_d = frame_q + FRAME_W'(1);
          end
        end
      end
      S_HIT: begin
        if (refresh_tick) begin
          if (hit_q == HIT_LAST) begin
            if (lives_q == 2'd0) begin
              state_d = S_OVER;
            end else begin
              state_d = S_PLAY;
              clear_d = 1'b1;
            end
          end else begin
            hit_d = hit_q + HIT_W'(1);
          end
        end
      end
      S_OVER: begin
        if (start_evt_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    game_en_d = (state_d == S_PLAY);
    // min(1 + level/2, 7): only levels 14 and 15 would overflow.
    speed_d = (level_d[3:1] == 3'd7) ? 3'd7 : 3'd1 + level_d[3:1];
  end

  assign state       = state_q;
  assign game_en     = game_en_q;
  assign clear       = clear_q;
  assign num_enabled = num_q;
  assign speed       = speed_q;
  assign level       = level_q;
  assign lives       = lives_q;

endmodule

// File: tb/tb_game_control.sv
module tb_game_control;

  localparam int FPL = 4;
  localparam int HF  = 2;
  localparam int SQ  = 4;
  localparam int LV  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       collision = 1'b0;
  logic [1:0] state;
  logic       game_en;
  logic       clear;
  logic [4:0] num_enabled;
  logic [2:0] speed;
  logic [3:0] level;
  logic [1:0] lives;

  int n_cmp = 0;
  int n_bad = 0;

  game_control #(
    .FRAMES_PER_LEVEL(FPL),
    .HIT_FRAMES(HF),
    .START_SQUARES(SQ),
    .LIVES(LV)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .refresh_tick(tick),
    .start(start),
    .collision(collision),
    .state(state),
    .game_en(game_en),
    .clear(clear),
    .num_enabled(num_enabled),
    .speed(speed),
    .level(level),
    .lives(lives)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock cycle: inputs change on the falling edge, return just after the rising edge.
  task automatic step(input logic rn, input logic tk, input logic st, input logic col);
    @(negedge clk);
    rst_n = rn; tick = tk; start = st; collision = col;
    @(posedge clk);
    #2;
  endtask

  // Behavioural model: level progress is derived from the total count of
  // collision-free PLAY frames in the current game.
  int m_state = 0, m_lives = 0, m_play = 0, m_hit = 0;
  bit m_clear = 0, m_prev = 0, m_armed = 0;

  initial begin
    bit s_rn, s_tk, s_st, s_col, ev;
    int lvl, num, spd;
    forever begin
      @(posedge clk);
      s_rn = rst_n; s_tk = tick; s_st = start; s_col = collision;
      if (!s_rn) begin
        m_state = 0; m_lives = 0; m_play = 0; m_hit = 0;
        m_clear = 0; m_prev = 0; m_armed = 0;
      end else begin
        ev = s_st && !m_prev && m_armed;
        m_armed = m_armed || !s_st;
        m_prev = s_st;
        m_clear = 0;
        case (m_state)
          0: if (ev) begin
               m_state = 1; m_clear = 1; m_lives = LV; m_play = 0;
             end
          1: if (s_tk) begin
               if (s_col) begin
                 m_state = 2; m_hit = 0;
                 if (m_lives > 0) m_lives = m_lives - 1;
               end else begin
                 m_play = m_play + 1;
               end
             end
          2: if (s_tk) begin
               m_hit = m_hit + 1;
               if (m_hit == HF) begin
                 if (m_lives == 0) m_state = 3;
                 else begin m_state = 1; m_clear = 1; end
               end
             end
          default: if (ev) m_state = 0;
        endcase
      end
      #1;
      lvl = m_play / FPL; if (lvl > 15) lvl = 15;
      num = SQ + m_play / FPL; if (num > 16) num = 16;
      spd = 1 + lvl / 2; if (spd > 7) spd = 7;
      chk("m_state", 8'(state), 8'(m_state));
      chk("m_game_en", 8'(game_en), 8'(m_state == 1));
      chk("m_clear", 8'(clear), 8'(m_clear));
      chk("m_lives", 8'(lives), 8'(m_lives));
      chk("m_level", 8'(level), 8'(lvl));
      chk("m_num", 8'(num_enabled), 8'(num));
      chk("m_speed", 8'(speed), 8'(spd));
    end
  end

  initial begin
    logic st;
    // Reset state
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_num", 8'(num_enabled), 8'd4);
    chk("rst_speed", 8'(speed), 8'd1);
    chk("rst_lives", 8'(lives), 8'd0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    // Collision in IDLE is ignored
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("idle_col_state", 8'(state), 8'd0);
    // Start -> PLAY with clear
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("go_state", 8'(state), 8'd1);
    chk("go_game_en", 8'(game_en), 8'd1);
    chk("go_clear", 8'(clear), 8'd1);
    chk("go_lives", 8'(lives), 8'd2);
    chk("go_level", 8'(level), 8'd0);
    chk("go_num", 8'(num_enabled), 8'd4);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("clear_one", 8'(clear), 8'd0);
    // Collision between ticks is ignored
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("notick_col", 8'(state), 8'd1);
    repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("l2_level", 8'(level), 8'd2);
    chk("l2_num", 8'(num_enabled), 8'd6);
    chk("l2_speed", 8'(speed), 8'd2);
    repeat (56) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat_level", 8'(level), 8'd15);
    chk("sat_num", 8'(num_enabled), 8'd16);
    chk("sat_speed", 8'(speed), 8'd7);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat2_level", 8'(level), 8'd15);
    chk("sat2_num", 8'(num_enabled), 8'd16);
    // Collision on a level-step frame
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("hit_state", 8'(state), 8'd2);
    chk("hit_lives", 8'(lives), 8'd1);
    chk("hit_level", 8'(level), 8'd15);
    chk("hit_game_en", 8'(game_en), 8'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("hit_t1_state", 8'(state), 8'd2);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("hit_back_state", 8'(state), 8'd1);
    chk("hit_back_clear", 8'(clear), 8'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("play_start_ign", 8'(state), 8'd1);
    // Second collision -> OVER -> IDLE -> PLAY
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("hit2_lives", 8'(lives), 8'd0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("over_state", 8'(state), 8'd3);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("over_idle", 8'(state), 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("replay_state", 8'(state), 8'd1);
    chk("replay_lives", 8'(lives), 8'd2);
    chk("replay_level", 8'(level), 8'd0);
    // Async reset mid-HIT with start held high
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_state", 8'(state), 8'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_state", 8'(state), 8'd0);
    chk("arst_lives", 8'(lives), 8'd0);
    chk("arst_num", 8'(num_enabled), 8'd4);
    chk("arst_speed", 8'(speed), 8'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("held_start_idle", 8'(state), 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("fresh_start", 8'(state), 8'd1);

    // Randomised phase, checked by the model every cycle
    st = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) st = ~st;
      step(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)), st,
           ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_control.md
GAME_CONTROL -- requirements
Module: game_control

Interface
REQ-001 Parameter FRAMES_PER_LEVEL, default 600, SHALL set the refresh ticks spent in PLAY per level step (legal range 2..1023).
REQ-002 Parameter HIT_FRAMES, default 60, SHALL set the refresh ticks spent in HIT (legal range 1..255).
REQ-003 Parameter START_SQUARES, default 4, SHALL set num_enabled at game start (legal range 1..16).
REQ-004 Parameter LIVES, default 3, SHALL set the lives loaded at game start (legal range 1..3).
REQ-005 Ports SHALL be, clock and reset first:
  clk  in  1  system clock, all state on rising edge
  reset  in  1  asynchronous, active-low reset
  refresh_tick  in  1  one-clk pulse per video frame
  start  in  1  debounced start button, level-sensitive
  collision  in  1  game_status collision flag, 1 = main square hit
  state  out  2  00 IDLE, 01 PLAY, 10 HIT, 11 OVER
  game_en  out  1  square-motion enable
  clear  out  1  one-clk pulse: re-initialise all square positions
  num_enabled  out  5  enemy squares active, 1..16
  speed  out  3  pixels per frame for enemy squares, 1..7
  level  out  4  current level, 0..15
  lives  out  2  remaining lives

Function
REQ-006 Block SHALL detect the rising edge of start with a registered copy; only a 0->1 transition is a start event.
REQ-007 IDLE: on a start event, SHALL go to PLAY next clk, pulse clear for exactly one clk, load lives=LIVES, level=0, num_enabled=START_SQUARES, frame counter=0.
REQ-008 game_en SHALL be 1 exactly when state=PLAY, registered, no combinational path from inputs.
REQ-009 collision and level timing SHALL be evaluated only in clks where refresh_tick=1 and state=PLAY; collision outside those clks SHALL be ignored.
REQ-010 PLAY, refresh_tick=1, collision=0: frame counter +1; on reaching FRAMES_PER_LEVEL-1 it SHALL wrap to 0 and, in the same clk, level and num_enabled each SHALL increment, saturating at 15 and 16 respectively.
REQ-011 PLAY, refresh_tick=1, collision=1: SHALL go to HIT, decrement lives (no underflow), clear hit counter; frame counter and level SHALL hold. Collision has priority over a simultaneous level step.
REQ-012 HIT: hit counter SHALL increment per refresh_tick; on the tick where it reaches HIT_FRAMES-1: lives=0 -> OVER; else -> PLAY with one-clk clear pulse, level/num_enabled/frame counter unchanged.
REQ-013 OVER: SHALL hold level, lives=0 and num_enabled; on a start event SHALL go to IDLE (not directly to PLAY).
REQ-014 Start events in PLAY and HIT SHALL be ignored.
REQ-015 speed SHALL equal min(1 + level/2, 7), integer division, registered or derived from the level register only.
REQ-016 clear SHALL never be high in two consecutive clks.

Reset
REQ-017 reset=0 SHALL immediately force state=IDLE, game_en=0, clear=0, level=0, lives=0, num_enabled=START_SQUARES, speed=1, all counters and the start-edge register to 0, regardless of clk.
REQ-018 Reset asserted mid-PLAY or mid-HIT SHALL abandon the game; after release the block SHALL wait in IDLE for a new start event, even if start is held high (edge register cleared to 0 requires a fresh 0->1 only if start is low at release; start held high through release SHALL NOT count as an edge).

Verification (FRAMES_PER_LEVEL=4, HIT_FRAMES=2, START_SQUARES=4, LIVES=2)
REQ-019 Reset then start pulse -> one clk later state=01, game_en=1, clear=1 for one clk, lives=2, level=0, num_enabled=4, speed=1.
REQ-020 PLAY, 8 ticks no collision -> level=2, num_enabled=6, speed=2; continue to 64 ticks -> level=15, num_enabled=16, speed=7, no further change after 4 more ticks.
REQ-021 collision=1 on a tick that is also the 4th frame -> state=10, lives=1, level unchanged, game_en=0; after 2 ticks -> state=01 with one clear pulse.
REQ-022 Second collision -> HIT, lives=0; after 2 ticks -> state=11; start edge -> state=00; next start edge -> PLAY with lives=2, level=0.
REQ-023 collision held high in IDLE and between ticks in PLAY -> no state change; start toggled during PLAY/HIT -> no effect.
REQ-024 reset pulsed low mid-HIT with start held high -> all outputs at reset values asynchronously; stays IDLE until start goes low then high.
